uart_rx_fifo_ctrl: RTL

Parametrised UART receive FIFO with 16550-style status and interrupt generation. It sits between the RX deserialiser, which pushes on rx_done, and the APB register interface, which pops on a read of the RBR.
It extends the previous receive buffer with the following:
- circular pointer storage instead of shifting
- configurable width and depth
- FCR-programmable trigger levels
- character timeout
- sticky overrun cleared on LSR read
- prioritised IIR encoding

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo_core.sv | 62 ++++++
 rtl/uart_rx_fifo_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the UART receive FIFO controller
package uart_pkg;

    typedef enum logic [3:0] {
        IIR_NONE = 4'b0001,
        IIR_RLS  = 4'b0110,
        IIR_RDA  = 4'b0100,
        IIR_CTI  = 4'b1100
    } iir_code_e;

    localparam int LSR_DR      = 0;
    localparam int LSR_OE      = 1;

    localparam int FCR_EN      = 0;
    localparam int FCR_CLR     = 1;
    localparam int FCR_TRIG_LO = 6;
    localparam int FCR_TRIG_HI = 7;

    function automatic int trigger_level(input logic [1:0] sel, input int depth);
        return sel == 2'b00 ? 1 : sel == 2'b01 ? depth / 4 : sel == 2'b10 ? depth / 2 : depth - 2;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: circular-buffer FIFO with occupancy counter and registered read
module sync_fifo_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [LW-1:0]     level,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, empty, do_push, do_pop;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle
    always_comb begin
        empty    = level == '0;
        full     = level == LW'(DEPTH);
        do_pop   = rd_en & ~clr & ~empty;
        do_push  = wr_en & ~clr & (~full | do_pop);
        overflow = wr_en & ~clr & full & ~rd_en;
    end

    // Storage write port, deliberately without reset
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

    // Pointers, occupancy and the registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (clr) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            data_out_valid <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr + AW'(do_push);
            rd_ptr         <= rd_ptr + AW'(do_pop);
            level          <= level + LW'(do_push) - LW'(do_pop);
            data_out_valid <= do_pop;
            if (do_pop)
                data_out <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: 16550-style receive FIFO with line status, timeout and interrupt ID
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 4096,
    localparam int LW         = $clog2(DEPTH) + 1,
    localparam int TW         = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              lsr_rd,
    input  logic [7:0]        fcr,
    input  logic [3:0]        ier,
    output logic [7:0]        lsr,
    output logic [7:0]        iir,
    output logic              irq,
    output logic [LW-1:0]     level
);

    logic          clr, overflow, oe, tout_flag;
    logic [TW-1:0] tcnt;
    logic [LW-1:0] trig;
    logic [3:0]    code;
    logic          unused_ok;

    assign clr       = ~fcr[FCR_EN] | fcr[FCR_CLR];
    assign unused_ok = &{1'b0, ier[3], ier[1], fcr[5:2]};

    sync_fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_core (
        .clk            (clk),
        .reset          (reset),
        .clr            (clr),
        .wr_en          (wr_en),
        .data_in        (data_in),
        .rd_en          (rd_en),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .level          (level),
        .overflow       (overflow)
    );

    // Trigger threshold, status bits and prioritised interrupt source
    always_comb begin
        trig      = LW'(trigger_level(fcr[FCR_TRIG_HI:FCR_TRIG_LO], DEPTH));
        tout_flag = tcnt == TW'(TIMEOUT_CYC);
        lsr       = '0;
        lsr[LSR_DR] = level != '0;
        lsr[LSR_OE] = oe;
        code = (oe & ier[2])             ? IIR_RLS :
               (level >= trig & ier[0])  ? IIR_RDA :
               (tout_flag & ier[0])      ? IIR_CTI : IIR_NONE;
    end

    // Sticky overrun: a new overrun wins over a coincident LSR read
    always_ff @(posedge clk) begin
        if (reset)
            oe <= 1'b0;
        else if (overflow)
            oe <= 1'b1;
        else if (lsr_rd)
            oe <= 1'b0;
    end

    // Idle counter that saturates once the character timeout is reached
    always_ff @(posedge clk) begin
        if (reset)
            tcnt <= '0;
        else
            tcnt <= (clr | wr_en | rd_en | level == '0) ? '0 : tout_flag ? tcnt : tcnt + 1'b1;
    end

    // Interrupt identification, re-evaluated every cycle
    always_ff @(posedge clk) begin
        if (reset)
            iir <= 8'h01;
        else
            iir <= {{2{fcr[FCR_EN]}}, 2'b00, code};
    end

    assign irq = ~iir[0];

endmodule
